// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mem_arb_pkg                                                     |
// | Purpose  : Shared types and defaults for the memory port arbiter: FSM      |
// |            state encoding, requester source id, parameter defaults.        |
// | Config   : ARB_ROUND_ROBIN_EN (consumed by arbiter and picker, not here)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int A_WIDTH_DEF      = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    // Wide enough for the largest legal STARVE_LIMIT (15).
    localparam int CNT_W            = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: mem_port_arbiter_if                                             |
// | Purpose  : Bundles the I-cache, D-cache and memory-side signals of the     |
// |            memory port arbiter. The arbiter uses the slave modport, the    |
// |            surrounding caches/memory use the master modport.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
    parameter int A_WIDTH = 32
) ();
    // I-cache side
    logic [A_WIDTH-1:0] i_a;
    logic               i_strobe;
    logic [31:0]        i_din;
    logic               i_ready;
    // D-cache side
    logic [A_WIDTH-1:0] d_a;
    logic [31:0]        d_dout;
    logic               d_wr;
    logic               d_strobe;
    logic [31:0]        d_din;
    logic               d_ready;
    // Memory side
    logic [A_WIDTH-1:0] m_a;
    logic [31:0]        m_din;
    logic               m_wr;
    logic               m_strobe;
    logic [31:0]        m_dout;
    logic               m_ready;

    modport slave (
        input  i_a, i_strobe, d_a, d_dout, d_wr, d_strobe, m_dout, m_ready,
        output i_din, i_ready, d_din, d_ready, m_a, m_din, m_wr, m_strobe
    );

    modport master (
        output i_a, i_strobe, d_a, d_dout, d_wr, d_strobe, m_dout, m_ready,
        input  i_din, i_ready, d_din, d_ready, m_a, m_din, m_wr, m_strobe
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arb_pick                                                    |
// | Purpose  : Combinational grant selection between I and D requesters.       |
// |            Default: D wins a tie unless the starvation limit is hit.       |
// |            ARB_ROUND_ROBIN_EN: a tie goes to the side opposite last grant. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  wire logic     i_req_i,
    input  wire logic     d_req_i,
    input  wire logic     starve_hit_i,
    input  arb_src_e      last_grant_i,
    output logic          grant_valid_o,
    output arb_src_e      grant_src_o
);

`ifdef ARB_ROUND_ROBIN_EN
    // The starvation counter has no role in round-robin mode.
    logic unused_starve;
    assign unused_starve = starve_hit_i;
`else
    // History is only needed for round-robin tie breaking.
    logic unused_last;
    assign unused_last = last_grant_i;
`endif

    // Pick the source for the next transaction from the current requests.
    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        grant_src_o   = SRC_D;
        if (i_req_i && !d_req_i) begin
            grant_src_o = SRC_I;
        end else if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_src_o = (last_grant_i == SRC_I) ? SRC_D : SRC_I;
`else
            grant_src_o = starve_hit_i ? SRC_I : SRC_D;
`endif
        end
    end

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                |
// | Purpose  : Shares one external memory port between I-cache misses and     |
// |            D-cache misses/writes. One transaction in flight; grant held    |
// |            until m_ready; one IDLE cycle between transactions.             |
// | Config   : ARB_ROUND_ROBIN_EN - alternate on ties instead of fixed D       |
// |            priority with starvation counter.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int A_WIDTH      = A_WIDTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_arbiter_if.slave   arb
);

    arb_state_e          state_q;
    arb_src_e            last_grant_q;
    logic [CNT_W-1:0]    starve_cnt_q;
    logic                m_strobe_q;
    logic                m_wr_q;
    logic [A_WIDTH-1:0]  m_a_q;
    logic [31:0]         m_din_q;

    logic                starve_hit;
    logic                grant_valid;
    arb_src_e            grant_src;

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .i_req_i       (arb.i_strobe),
        .d_req_i       (arb.d_strobe),
        .starve_hit_i  (starve_hit),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_src_o   (grant_src)
    );

    // Arbiter FSM: latch the granted request onto the memory port, release on m_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_I;
            starve_cnt_q <= '0;
            m_strobe_q   <= 1'b0;
            m_wr_q       <= 1'b0;
            m_a_q        <= '0;
            m_din_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant_q <= grant_src;
                        m_strobe_q   <= 1'b1;
                        if (grant_src == SRC_D) begin
                            state_q <= GNT_D;
                            m_a_q   <= arb.d_a;
                            m_din_q <= arb.d_dout;
                            m_wr_q  <= arb.d_wr;
`ifndef ARB_ROUND_ROBIN_EN
                            // Count D wins that made a waiting I side wait longer.
                            if (arb.i_strobe && !starve_hit) begin
                                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                            end
`endif
                        end else begin
                            state_q      <= GNT_I;
                            m_a_q        <= arb.i_a;
                            m_din_q      <= '0;
                            m_wr_q       <= 1'b0;
                            starve_cnt_q <= '0;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (arb.m_ready) begin
                        state_q    <= IDLE;
                        m_strobe_q <= 1'b0;
                        m_wr_q     <= 1'b0;
                        m_a_q      <= '0;
                        m_din_q    <= '0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    m_strobe_q <= 1'b0;
                end
            endcase
        end
    end

    assign arb.m_strobe = m_strobe_q;
    assign arb.m_wr     = m_wr_q;
    assign arb.m_a      = m_a_q;
    assign arb.m_din    = m_din_q;

    // Completion goes only to the side holding the grant; m_ready elsewhere is ignored.
    assign arb.i_ready  = arb.m_ready & (state_q == GNT_I);
    assign arb.d_ready  = arb.m_ready & (state_q == GNT_D);
    assign arb.i_din    = arb.m_dout;
    assign arb.d_din    = arb.m_dout;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                             |
// | Purpose  : Self-checking bench for mem_port_arbiter: random requesters and |
// |            memory latency against a transaction-level reference model,     |
// |            plus directed grant-order, fixed-value and reset scenarios.     |
// | Config   : ARB_ROUND_ROBIN_EN selects the round-robin expectations.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.A_WIDTH(AW)) bus ();

    mem_port_arbiter #(.A_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (transaction level)
    bit          mb_busy;
    bit          mb_src;      // 0 = I, 1 = D
    logic [31:0] mb_a, mb_din;
    bit          mb_wr;
    int          starve;      // consecutive D wins while I was waiting
    bit          last_d;
    bit          done_i, done_d;
    int          lat;
    logic [31:0] mem_data;

    // Stimulus knobs
    int pct_i, pct_d, pct_spur, pct_drop, min_lat, max_lat;
    bit hold, use_fixed;
    bit seen[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_cycle();
        bit exp_ri, exp_rd;
        exp_ri = mb_busy && !mb_src && (bus.m_ready === 1'b1);
        exp_rd = mb_busy &&  mb_src && (bus.m_ready === 1'b1);
        chk("m_strobe", bus.m_strobe, mb_busy);
        if (mb_busy) begin
            chk("m_a",   bus.m_a,   mb_a);
            chk("m_wr",  bus.m_wr,  mb_wr);
            chk("m_din", bus.m_din, mb_din);
        end
        chk("i_ready", bus.i_ready, exp_ri);
        chk("d_ready", bus.d_ready, exp_rd);
        if (exp_ri) chk("i_din", bus.i_din, mem_data);
        if (exp_rd) chk("d_din", bus.d_din, mem_data);
        if (bus.i_ready === 1'b1) seen.push_back(1'b0);
        if (bus.d_ready === 1'b1) seen.push_back(1'b1);
    endtask

    // Advance the model to what the next rising edge must produce.
    task automatic model_step();
        bit pick_d;
        done_i = 0;
        done_d = 0;
        if (mb_busy) begin
            if (bus.m_ready) begin
                mb_busy = 0;
                if (mb_src) done_d = 1; else done_i = 1;
            end
        end else if (bus.i_strobe || bus.d_strobe) begin
            if (!bus.i_strobe)      pick_d = 1;
            else if (!bus.d_strobe) pick_d = 0;
            else begin
`ifdef ARB_ROUND_ROBIN_EN
                pick_d = !last_d;
`else
                pick_d = (starve < LIM);
`endif
            end
            mb_busy = 1;
            mb_src  = pick_d;
            last_d  = pick_d;
            lat     = $urandom_range(max_lat, min_lat);
            if (pick_d) begin
                mb_a   = bus.d_a;
                mb_din = bus.d_dout;
                mb_wr  = bus.d_wr;
`ifndef ARB_ROUND_ROBIN_EN
                if (bus.i_strobe) starve = (starve + 1 > LIM) ? LIM : starve + 1;
`endif
            end else begin
                mb_a   = bus.i_a;
                mb_din = 32'h0;
                mb_wr  = 0;
                starve = 0;
            end
        end
    endtask

    task automatic drive();
        bit infl_i, infl_d;
        // Memory responder
        if (bus.m_ready) begin
            bus.m_ready = 1'b0;
        end else if (mb_busy) begin
            if (lat == 0) begin
                mem_data    = use_fixed ? 32'h3C1DBFC0 : $urandom;
                bus.m_dout  = mem_data;
                bus.m_ready = 1'b1;
            end else begin
                lat--;
            end
        end else if ($urandom_range(99, 0) < pct_spur) begin
            mem_data    = $urandom;
            bus.m_dout  = mem_data;
            bus.m_ready = 1'b1;
        end
        infl_i = mb_busy && !mb_src;
        infl_d = mb_busy &&  mb_src;
        // I requester
        if (done_i) bus.i_strobe = 1'b0;
        if (!bus.i_strobe && !infl_i && (hold || $urandom_range(99, 0) < pct_i)) begin
            bus.i_strobe = 1'b1;
            bus.i_a      = use_fixed ? 32'hBFC00000 : $urandom;
        end else if (bus.i_strobe && infl_i && !hold && $urandom_range(99, 0) < pct_drop) begin
            bus.i_strobe = 1'b0;
        end
        // D requester
        if (done_d) bus.d_strobe = 1'b0;
        if (!bus.d_strobe && !infl_d && (hold || $urandom_range(99, 0) < pct_d)) begin
            bus.d_strobe = 1'b1;
            bus.d_a      = use_fixed ? 32'h80001000 : $urandom;
            bus.d_dout   = use_fixed ? 32'hDEADBEEF : $urandom;
            bus.d_wr     = use_fixed ? 1'b1 : 1'($urandom_range(1, 0));
        end else if (bus.d_strobe && infl_d && !hold && $urandom_range(99, 0) < pct_drop) begin
            bus.d_strobe = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        model_step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic quiesce();
        pct_i = 0; pct_d = 0; pct_spur = 0; pct_drop = 0; hold = 0;
        run(20);
    endtask

    task automatic model_reset();
        mb_busy = 0; mb_src = 0; mb_a = 0; mb_din = 0; mb_wr = 0;
        starve = 0; last_d = 0; done_i = 0; done_d = 0; lat = 0;
    endtask

    initial begin
        bit exp_order[10];
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
        rst = 1'b1;
        bus.i_a = '0; bus.i_strobe = 0; bus.d_a = '0; bus.d_dout = '0;
        bus.d_wr = 0; bus.d_strobe = 0; bus.m_dout = '0; bus.m_ready = 0;
        mem_data = '0;
        pct_i = 0; pct_d = 0; pct_spur = 0; pct_drop = 0;
        min_lat = 0; max_lat = 0; hold = 0; use_fixed = 0;
        model_reset();

        #12;
        chk("rst_m_strobe", bus.m_strobe, 0);
        chk("rst_m_wr",     bus.m_wr,     0);
        chk("rst_m_a",      bus.m_a,      0);
        chk("rst_m_din",    bus.m_din,    0);
        chk("rst_i_ready",  bus.i_ready,  0);
        chk("rst_d_ready",  bus.d_ready,  0);
        @(negedge clk);
        rst = 1'b0;

        // Both sides held continuously with single-cycle memory: grant order.
        hold = 1;
        @(posedge clk); #1;
        drive();
        seen.delete();
        run(44);
        quiesce();
        if (seen.size() < 10) begin
            chk("grant_count", seen.size(), 10);
        end else begin
            for (int k = 0; k < 10; k++)
                chk($sformatf("grant_order[%0d]", k), seen[k], exp_order[k]);
        end

        // Fixed-value I reads then D writes, three-cycle memory latency.
        use_fixed = 1; min_lat = 3; max_lat = 3;
        pct_i = 100;
        run(12);
        quiesce();
        pct_d = 100;
        run(12);
        quiesce();
        use_fixed = 0;

        // Random traffic with spurious m_ready and strobes dropped mid-grant.
        pct_i = 40; pct_d = 45; pct_spur = 10; pct_drop = 8;
        min_lat = 0; max_lat = 4;
        run(3000);
        quiesce();

        // Asynchronous reset in the middle of a D grant.
        pct_d = 100; min_lat = 6; max_lat = 6;
        for (int k = 0; k < 10 && !(mb_busy && mb_src); k++) cycle();
        chk("reset_setup_gnt_d", mb_busy && mb_src, 1);
        #2;
        rst = 1'b1;
        bus.i_strobe = 0; bus.d_strobe = 0; bus.m_ready = 0; pct_d = 0;
        #1;
        chk("async_rst_m_strobe", bus.m_strobe, 0);
        chk("async_rst_d_ready",  bus.d_ready,  0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        bus.m_ready = 1'b1;   // stray completion after reset must be ignored
        run(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
